axi_rd_arbiter: RTL and testbench

- Two-requester AXI read-channel arbiter.
- Shares the single io_master AR/R port between the instruction cache (s0) and the LSU/data side (s1).
- Grants one whole burst at a time, forwards the AR fields of the granted requester and routes R beats back to it.
- Includes a stall watchdog for bring-up debug.

---
 rtl/axi_rd_arbiter_if.sv | 68 ++++++
 rtl/axi_rd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Bundle of every handshake/bus signal around the two-requester AXI read arbiter.
//   s0_*        : instruction-cache requester AR/R channel
//   s1_*        : LSU/data requester AR/R channel
//   io_master_* : shared downstream AR/R channel
// Modports:
//   slave  : the arbiter's view (takes requests, drives the downstream port)
//   master : the surrounding environment's view (requesters plus downstream memory)
interface axi_rd_arbiter_if;
    logic        s0_arvalid;
    logic        s0_arready;
    logic [31:0] s0_araddr;
    logic [7:0]  s0_arlen;
    logic [2:0]  s0_arsize;
    logic [1:0]  s0_arburst;
    logic        s0_rvalid;
    logic        s0_rready;
    logic [63:0] s0_rdata;
    logic [1:0]  s0_rresp;
    logic        s0_rlast;

    logic        s1_arvalid;
    logic        s1_arready;
    logic [31:0] s1_araddr;
    logic [7:0]  s1_arlen;
    logic [2:0]  s1_arsize;
    logic [1:0]  s1_arburst;
    logic        s1_rvalid;
    logic        s1_rready;
    logic [63:0] s1_rdata;
    logic [1:0]  s1_rresp;
    logic        s1_rlast;

    logic        io_master_arvalid;
    logic        io_master_arready;
    logic [31:0] io_master_araddr;
    logic [3:0]  io_master_arid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid;
    logic        io_master_rready;
    logic [63:0] io_master_rdata;
    logic [1:0]  io_master_rresp;
    logic        io_master_rlast;
    logic [3:0]  io_master_rid;

    modport slave (
        input  s0_arvalid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_rready,
        output s0_arready, s0_rvalid, s0_rdata, s0_rresp, s0_rlast,
        input  s1_arvalid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_rready,
        output s1_arready, s1_rvalid, s1_rdata, s1_rresp, s1_rlast,
        output io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
        output io_master_arsize, io_master_arburst, io_master_rready,
        input  io_master_arready, io_master_rvalid, io_master_rdata, io_master_rresp,
        input  io_master_rlast, io_master_rid
    );

    modport master (
        output s0_arvalid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_rready,
        input  s0_arready, s0_rvalid, s0_rdata, s0_rresp, s0_rlast,
        output s1_arvalid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_rready,
        input  s1_arready, s1_rvalid, s1_rdata, s1_rresp, s1_rlast,
        input  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
        input  io_master_arsize, io_master_arburst, io_master_rready,
        output io_master_arready, io_master_rvalid, io_master_rdata, io_master_rresp,
        output io_master_rlast, io_master_rid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read-channel arbiter. Shares one downstream AR/R port between the
// instruction cache (s0) and the LSU (s1), one whole burst at a time, with a sticky stall
// watchdog for bring-up debug.
// Ports:
//   clock     : single clock, everything on posedge
//   reset     : synchronous active-low reset
//   bus_io    : axi_rd_arbiter_if.slave, both requester channels and the downstream port
//   timeout_o : sticky flag, set after TIMEOUT busy cycles without AR/R handshake progress
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, contention grants the requester that was not granted
//                        last; otherwise s1 has fixed priority.
module axi_rd_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    axi_rd_arbiter_if.slave   bus_io,
    output logic              timeout_o
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StAr0, StR0, StAr1, StR1} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               ar_hs, r_hs;

    // The downstream ID is not checked on return; beats are routed by FSM state.
    logic [3:0] unused_rid;
    assign unused_rid = bus_io.io_master_rid;

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_hs        = 1'b0;
        r_hs         = 1'b0;

        bus_io.s0_arready = 1'b0;
        bus_io.s0_rvalid  = 1'b0;
        bus_io.s0_rdata   = '0;
        bus_io.s0_rresp   = '0;
        bus_io.s0_rlast   = 1'b0;
        bus_io.s1_arready = 1'b0;
        bus_io.s1_rvalid  = 1'b0;
        bus_io.s1_rdata   = '0;
        bus_io.s1_rresp   = '0;
        bus_io.s1_rlast   = 1'b0;

        bus_io.io_master_arvalid = 1'b0;
        bus_io.io_master_araddr  = '0;
        bus_io.io_master_arid    = '0;
        bus_io.io_master_arlen   = '0;
        bus_io.io_master_arsize  = '0;
        bus_io.io_master_arburst = '0;
        bus_io.io_master_rready  = 1'b0;

        // Outputs are held low for the whole reset cycle, not only after the reset edge.
        if (reset) begin
            unique case (state_q)
                StIdle: begin
                    // Grants are registered: a request seen here shows up downstream next cycle.
                    if (bus_io.s0_arvalid && bus_io.s1_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
                        state_d = last_grant_q ? StAr0 : StAr1;
`else
                        state_d = StAr1;
`endif
                    end else if (bus_io.s0_arvalid) begin
                        state_d = StAr0;
                    end else if (bus_io.s1_arvalid) begin
                        state_d = StAr1;
                    end
                end
                StAr0: begin
                    bus_io.io_master_arvalid = 1'b1;
                    bus_io.io_master_araddr  = bus_io.s0_araddr;
                    bus_io.io_master_arid    = 4'd0;
                    bus_io.io_master_arlen   = bus_io.s0_arlen;
                    bus_io.io_master_arsize  = bus_io.s0_arsize;
                    bus_io.io_master_arburst = bus_io.s0_arburst;
                    bus_io.s0_arready        = bus_io.io_master_arready;
                    if (bus_io.io_master_arready) begin
                        ar_hs        = 1'b1;
                        state_d      = StR0;
                        last_grant_d = 1'b0;
                    end
                end
                StR0: begin
                    bus_io.s0_rvalid        = bus_io.io_master_rvalid;
                    bus_io.s0_rdata         = bus_io.io_master_rdata;
                    bus_io.s0_rresp         = bus_io.io_master_rresp;
                    bus_io.s0_rlast         = bus_io.io_master_rlast;
                    bus_io.io_master_rready = bus_io.s0_rready;
                    if (bus_io.io_master_rvalid && bus_io.s0_rready) begin
                        r_hs = 1'b1;
                        if (bus_io.io_master_rlast) begin
                            state_d = StIdle;
                        end
                    end
                end
                StAr1: begin
                    bus_io.io_master_arvalid = 1'b1;
                    bus_io.io_master_araddr  = bus_io.s1_araddr;
                    bus_io.io_master_arid    = 4'd1;
                    bus_io.io_master_arlen   = bus_io.s1_arlen;
                    bus_io.io_master_arsize  = bus_io.s1_arsize;
                    bus_io.io_master_arburst = bus_io.s1_arburst;
                    bus_io.s1_arready        = bus_io.io_master_arready;
                    if (bus_io.io_master_arready) begin
                        ar_hs        = 1'b1;
                        state_d      = StR1;
                        last_grant_d = 1'b1;
                    end
                end
                StR1: begin
                    bus_io.s1_rvalid        = bus_io.io_master_rvalid;
                    bus_io.s1_rdata         = bus_io.io_master_rdata;
                    bus_io.s1_rresp         = bus_io.io_master_rresp;
                    bus_io.s1_rlast         = bus_io.io_master_rlast;
                    bus_io.io_master_rready = bus_io.s1_rready;
                    if (bus_io.io_master_rvalid && bus_io.s1_rready) begin
                        r_hs = 1'b1;
                        if (bus_io.io_master_rlast) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Watchdog: counts busy cycles with no handshake, saturating so the flag stays meaningful.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle || ar_hs || r_hs) begin
            cnt_d = '0;
        end else if (cnt_q != TimeoutCnt) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (cnt_d == TimeoutCnt);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign timeout_o = timeout_q & reset;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    localparam int unsigned TO = 8;

    logic clock = 1'b0;
    logic reset;
    logic timeout_o;

    always #5 clock = ~clock;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(
        .TIMEOUT (TO),
        .CNT_W   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_io    (bus),
        .timeout_o (timeout_o)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent chance of a handshake signal being high each cycle).
    int ar_pct = 100;
    int rv_pct = 100;
    int rr_pct = 100;
    bit auto_req = 1'b0;

    // Requesters: a pending request is held until the model says it was accepted.
    bit          req_valid [2];
    logic [31:0] req_addr  [2];
    logic [7:0]  req_len   [2];
    logic [2:0]  req_size  [2];
    logic [1:0]  req_burst [2];
    int          req_gap   [2];

    // Values driven in the current cycle.
    bit          ds_arready, ds_rvalid, ds_rlast;
    logic [63:0] ds_rdata;
    logic [1:0]  ds_rresp;
    bit          rr [2];

    // Reference model: which requester owns the port, and where its burst stands.
    int          m_grant;     // -1 when nobody owns the port
    bit          m_ar_phase;  // address not yet accepted downstream
    int          m_beat;      // index of the next beat to deliver
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    int          m_last;
    int          m_stall;
    bit          m_timeout;

    int arid_log [$];

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] enc_log(int q [$]);
        logic [127:0] v;
        v = 128'(q.size());
        foreach (q[i]) if (i < 16) v[8 + 4*i +: 4] = 4'(q[i] + 1);
        return v;
    endfunction

    task automatic check_log(string tag, int exp [$]);
        check(tag, enc_log(arid_log), enc_log(exp));
    endtask

    // Contention rule: round-robin hands the port to whoever was not served last.
    function automatic int pick(bit v0, bit v1);
        if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic void model_reset();
        m_grant = -1;
        m_ar_phase = 1'b0;
        m_beat = 0;
        m_last = 1;
        m_stall = 0;
        m_timeout = 1'b0;
    endfunction

    task automatic new_req(int x, logic [31:0] a, logic [7:0] l);
        req_valid[x] = 1'b1;
        req_addr[x]  = a;
        req_len[x]   = l;
        req_size[x]  = 3'd3;
        req_burst[x] = 2'd1;
    endtask

    task automatic step(bit rst_n);
        logic [49:0] e_ar;
        logic [68:0] e_s [2];
        logic        e_rr, e_to;
        bit          busy, progress;
        int          g;

        @(negedge clock);
        reset = rst_n;
        bus.s0_arvalid = req_valid[0];
        bus.s0_araddr  = req_addr[0];
        bus.s0_arlen   = req_len[0];
        bus.s0_arsize  = req_size[0];
        bus.s0_arburst = req_burst[0];
        bus.s1_arvalid = req_valid[1];
        bus.s1_araddr  = req_addr[1];
        bus.s1_arlen   = req_len[1];
        bus.s1_arsize  = req_size[1];
        bus.s1_arburst = req_burst[1];
        ds_arready = ($urandom_range(99) < ar_pct);
        ds_rvalid  = ($urandom_range(99) < rv_pct);
        ds_rresp   = 2'($urandom_range(3));
        if (m_grant >= 0 && !m_ar_phase) begin
            ds_rdata = {m_addr, 24'h0, 8'(m_beat)};
            ds_rlast = (m_beat == int'(m_len));
        end else begin
            ds_rdata = {$urandom, $urandom};
            ds_rlast = 1'($urandom_range(1));
        end
        bus.io_master_arready = ds_arready;
        bus.io_master_rvalid  = ds_rvalid;
        bus.io_master_rdata   = ds_rdata;
        bus.io_master_rresp   = ds_rresp;
        bus.io_master_rlast   = ds_rlast;
        bus.io_master_rid     = 4'($urandom_range(15));
        rr[0] = ($urandom_range(99) < rr_pct);
        rr[1] = ($urandom_range(99) < rr_pct);
        bus.s0_rready = rr[0];
        bus.s1_rready = rr[1];
        #1;

        e_ar = '0;
        e_s[0] = '0;
        e_s[1] = '0;
        e_rr = 1'b0;
        e_to = rst_n ? m_timeout : 1'b0;
        if (rst_n && m_grant >= 0) begin
            if (m_ar_phase) begin
                e_ar = {1'b1, 4'(m_grant), req_addr[m_grant], req_len[m_grant],
                        req_size[m_grant], req_burst[m_grant]};
                e_s[m_grant][68] = ds_arready;
            end else begin
                e_s[m_grant] = {1'b0, ds_rvalid, ds_rdata, ds_rresp, ds_rlast};
                e_rr = rr[m_grant];
            end
        end
        check("ar", {bus.io_master_arvalid, bus.io_master_arid, bus.io_master_araddr,
                     bus.io_master_arlen, bus.io_master_arsize, bus.io_master_arburst}, e_ar);
        check("s0", {bus.s0_arready, bus.s0_rvalid, bus.s0_rdata, bus.s0_rresp,
                     bus.s0_rlast}, e_s[0]);
        check("s1", {bus.s1_arready, bus.s1_rvalid, bus.s1_rdata, bus.s1_rresp,
                     bus.s1_rlast}, e_s[1]);
        check("rready", bus.io_master_rready, e_rr);
        check("timeout", timeout_o, e_to);
        if (rst_n && m_grant >= 0 && m_ar_phase && ds_arready)
            arid_log.push_back(int'(bus.io_master_arid));

        @(posedge clock);
        if (!rst_n) begin
            model_reset();
        end else begin
            busy = (m_grant >= 0);
            progress = 1'b0;
            if (m_grant < 0) begin
                g = pick(req_valid[0], req_valid[1]);
                if (g >= 0) begin
                    m_grant = g;
                    m_ar_phase = 1'b1;
                end
            end else if (m_ar_phase) begin
                if (ds_arready) begin
                    progress = 1'b1;
                    m_ar_phase = 1'b0;
                    m_beat = 0;
                    m_addr = req_addr[m_grant];
                    m_len = req_len[m_grant];
                    m_last = m_grant;
                    req_valid[m_grant] = 1'b0;
                    req_gap[m_grant] = int'($urandom_range(5));
                end
            end else if (ds_rvalid && rr[m_grant]) begin
                progress = 1'b1;
                if (m_beat == int'(m_len)) m_grant = -1;
                else m_beat++;
            end
            if (!busy || progress) m_stall = 0;
            else if (m_stall < int'(TO)) m_stall++;
            if (m_stall == int'(TO)) m_timeout = 1'b1;
            if (auto_req) begin
                for (int x = 0; x < 2; x++) begin
                    if (!req_valid[x]) begin
                        if (req_gap[x] == 0) new_req(x, $urandom & 32'hFFFF_FFC0,
                                                     8'($urandom_range(7)));
                        else req_gap[x]--;
                    end
                end
            end
        end
    endtask

    initial begin
        int exp_q [$];

        reset = 1'b0;
        for (int x = 0; x < 2; x++) begin
            req_valid[x] = 1'b0;
            req_addr[x]  = '0;
            req_len[x]   = '0;
            req_size[x]  = '0;
            req_burst[x] = '0;
            req_gap[x]   = 0;
        end
        model_reset();

        // Reset, then an idle cycle.
        step(1'b0);
        step(1'b0);
        step(1'b1);

        // Single s0 burst of four beats.
        new_req(0, 32'h8000_0010, 8'd3);
        repeat (10) step(1'b1);
        exp_q = {};
        exp_q.push_back(0);
        check_log("t1_grant", exp_q);

        // Simultaneous requests straight after reset.
        step(1'b0);
        arid_log.delete();
        new_req(0, 32'h0000_1000, 8'd1);
        new_req(1, 32'h0000_2000, 8'd1);
        repeat (20) step(1'b1);
        exp_q = {};
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(0);
        exp_q.push_back(1);
`else
        exp_q.push_back(1);
        exp_q.push_back(0);
`endif
        check_log("t2_order", exp_q);

        // Repeated contention rounds.
        arid_log.delete();
        repeat (2) begin
            new_req(0, 32'h0000_3000, 8'd1);
            new_req(1, 32'h0000_4000, 8'd1);
            repeat (20) step(1'b1);
        end
        exp_q = {};
        repeat (2) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_q.push_back(0);
            exp_q.push_back(1);
`else
            exp_q.push_back(1);
            exp_q.push_back(0);
`endif
        end
        check_log("t3_order", exp_q);

        // Downstream holds arready low for five cycles.
        new_req(0, 32'h1000_0040, 8'd2);
        ar_pct = 0;
        repeat (6) step(1'b1);
        ar_pct = 100;
        repeat (8) step(1'b1);

        // Requester backpressure mid-burst.
        new_req(0, 32'h2000_0000, 8'd7);
        repeat (4) step(1'b1);
        rr_pct = 0;
        repeat (3) step(1'b1);
        rr_pct = 100;
        repeat (10) step(1'b1);

        // Randomised traffic with occasional mid-burst resets.
        ar_pct = 60;
        rv_pct = 75;
        rr_pct = 75;
        auto_req = 1'b1;
        repeat (1500) step($urandom_range(199) != 0);

        auto_req = 1'b0;
        ar_pct = 100;
        rv_pct = 100;
        rr_pct = 100;
        repeat (40) step(1'b1);
        step(1'b0);

        // Watchdog: read data withheld.
        new_req(0, 32'h3000_0000, 8'd3);
        rv_pct = 0;
        repeat (12) step(1'b1);
        #2;
        check("t7_sticky", timeout_o, 1'b1);
        step(1'b0);
        rv_pct = 100;
        step(1'b1);
        #2;
        check("t7_cleared", timeout_o, 1'b0);
        repeat (10) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
